// File: rtl/sensor_spi_pkg.sv
// Shared definitions for the sensor SPI master: register map, bit positions, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sensor_spi_pkg;

   // Word offsets, decoded from address[2:0]
   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_TXDATA = 3'd1;
   localparam logic [2:0] REG_RXDATA = 3'd2;
   localparam logic [2:0] REG_STATUS = 3'd3;
   localparam logic [2:0] REG_CLKDIV = 3'd4;

   // CTRL / STATUS bit positions
   localparam int CTRL_START  = 8;
   localparam int CTRL_IRQ_EN = 9;
   localparam int STATUS_BUSY = 0;
   localparam int STATUS_DONE = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HIGH,
      ST_LOW,
      ST_HOLD,
      ST_GAP
   } spi_state_e;

   // LEN of 0 means a full 32-bit frame; values above 32 are clamped to 32
   // so the shadow alignment shift never goes negative.
   function automatic logic [5:0] eff_len(input logic [5:0] len);
      return (len == 6'd0 || len > 6'd32) ? 6'd32 : len;
   endfunction

   function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         r[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/sensor_spi_master_if.sv
// Avalon-MM slave bundle between the Nios bridge and the SPI master.
// Latency: reads return one cycle after acceptance.
// Backpressure: waitrequest stalls register writes while a frame is in flight.
// Ports: address/read/write/writedata/byteenable/burstcount/debugaccess from the
// master; readdata/readdatavalid/waitrequest back from the slave.
interface sensor_spi_master_if;
   logic [9:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        burstcount;
   logic        debugaccess;
   logic [31:0] readdata;
   logic        readdatavalid;
   logic        waitrequest;

   modport slave (
      input  address, read, write, writedata, byteenable, burstcount, debugaccess,
      output readdata, readdatavalid, waitrequest
   );

   modport master (
      output address, read, write, writedata, byteenable, burstcount, debugaccess,
      input  readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/sensor_spi_shifter.sv
// SPI mode-0 frame engine: FSM, half-period and bit counters, shift registers, MISO sync.
// Latency: frame = (2*LEN+2)*(DIV+1) + GAP_CYCLES cycles from the start edge to busy low.
// Backpressure: start is only honoured in IDLE; busy tells the caller when it may start again.
// Ports: clk/rst; start + len_in/tx_in/div_in shadow load; miso in; sclk/mosi/cs_n out;
// busy, done_evt (one-cycle, on the edge busy drops), rx_data (right-aligned capture).
module sensor_spi_shifter
   import sensor_spi_pkg::*;
#(
   parameter int GAP_CYCLES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  len_in,
   input  logic [31:0] tx_in,
   input  logic [7:0]  div_in,
   input  logic        miso,
   output logic        sclk,
   output logic        mosi,
   output logic        cs_n,
   output logic        busy,
   output logic        done_evt,
   output logic [31:0] rx_data
);

   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

   spi_state_e  state, state_nxt;
   logic [7:0]  hp_cnt;
   logic [7:0]  div_sh;
   logic [5:0]  bit_cnt;
   logic [5:0]  len_eff;
   logic [31:0] tx_sh;
   logic [31:0] tx_load;
   logic [31:0] rx_sh;
   logic        miso_s1, miso_s2;
   logic        phase_end;
   logic        enter;

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done_evt  = 1'b0;
      len_eff   = eff_len(len_in);
      // Left-align the frame so bit LEN-1 sits at bit 31 and leaves first.
      tx_load   = tx_in << (6'd32 - len_eff);
      phase_end = (state == ST_GAP) ? (hp_cnt == GAP_LAST) : (hp_cnt == div_sh);

      case (state)
         ST_IDLE:  if (start)     state_nxt = ST_SETUP;
         ST_SETUP: if (phase_end) state_nxt = ST_HIGH;
         ST_HIGH:  if (phase_end) state_nxt = ST_LOW;
         // After the last rising edge the clock still gets a full low phase
         // before the hold half-period, keeping SCLK symmetric at frame end.
         ST_LOW:   if (phase_end) state_nxt = (bit_cnt == 6'd0) ? ST_HOLD : ST_HIGH;
         ST_HOLD:  if (phase_end) state_nxt = ST_GAP;
         ST_GAP:   if (phase_end) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase

      busy     = (state != ST_IDLE);
      done_evt = (state == ST_GAP) && phase_end;
      enter    = (state_nxt != state);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         miso_s1 <= 1'b0;
         miso_s2 <= 1'b0;
         sclk    <= 1'b0;
         cs_n    <= 1'b1;
         hp_cnt  <= 8'd0;
         div_sh  <= 8'd0;
         bit_cnt <= 6'd0;
         tx_sh   <= '0;
         rx_sh   <= '0;
      end else begin
         miso_s1 <= miso;
         miso_s2 <= miso_s1;
         // Pins follow the state being entered so they change on the same edge.
         sclk    <= (state_nxt == ST_HIGH);
         cs_n    <= (state_nxt == ST_IDLE) || (state_nxt == ST_GAP);
         hp_cnt  <= enter ? 8'd0 : hp_cnt + 8'd1;
         if (enter) begin
            case (state_nxt)
               ST_SETUP: begin
                  div_sh  <= div_in;
                  bit_cnt <= len_eff;
                  tx_sh   <= tx_load;
                  rx_sh   <= '0;
               end
               ST_HIGH: begin
                  rx_sh   <= {rx_sh[30:0], miso_s2};
                  bit_cnt <= bit_cnt - 6'd1;
               end
               // bit_cnt already counts the bit just sampled; no shift after the last one.
               ST_LOW:   if (bit_cnt != 6'd0) tx_sh <= {tx_sh[30:0], 1'b0};
               ST_GAP:   tx_sh <= '0;
               default:  ;
            endcase
         end
      end
   end

   // tx_sh is a register, so mosi is a direct flop output.
   assign mosi    = tx_sh[31];
   assign rx_data = rx_sh;

endmodule

// File: rtl/sensor_spi_master.sv
// Avalon-MM register front end for the image-sensor SPI master; holds regs, decode and irq.
// Latency: readdatavalid exactly one cycle after an accepted read; reads fully pipelined.
// Backpressure: CTRL/TXDATA/CLKDIV writes stall on waitrequest while a frame is busy.
// Ports: clk_clk, reset_reset (async, active high); avs Avalon slave bundle;
// spi_sclk/spi_mosi/spi_cs_n out, spi_miso in; irq = DONE & IRQ_EN.
module sensor_spi_master
   import sensor_spi_pkg::*;
#(
   parameter logic [7:0] DIV_RESET  = 8'd4,
   parameter int         GAP_CYCLES = 8
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   sensor_spi_master_if.slave  avs,
   output logic                spi_sclk,
   output logic                spi_mosi,
   output logic                spi_cs_n,
   input  logic                spi_miso,
   output logic                irq
);

   logic [2:0]  addr;
   logic        busy;
   logic        done_evt;
   logic [31:0] rx_data;
   logic        stall_reg;
   logic        wr_ok;
   logic        start;
   logic [5:0]  len_start;
   logic [31:0] rd_mux;

   logic [5:0]  len_q;
   logic        irq_en_q;
   logic [31:0] txdata_q;
   logic [7:0]  clkdiv_q;
   logic        done_q;

   logic        unused_ok;
   assign unused_ok = ^{avs.address[9:3], avs.burstcount, avs.debugaccess};

   always_comb begin
      addr      = avs.address[2:0];
      stall_reg = (addr == REG_CTRL) || (addr == REG_TXDATA) || (addr == REG_CLKDIV);
      avs.waitrequest = avs.write && stall_reg && busy;
      wr_ok     = avs.write && !avs.waitrequest;
      // A START write may carry a new LEN in byte 0; the frame must use it.
      start     = wr_ok && (addr == REG_CTRL) && avs.byteenable[1] && avs.writedata[CTRL_START];
      len_start = avs.byteenable[0] ? avs.writedata[5:0] : len_q;

      rd_mux = 32'd0;
      case (addr)
         REG_CTRL:   rd_mux = {22'd0, irq_en_q, 3'd0, len_q};
         REG_TXDATA: rd_mux = txdata_q;
         REG_RXDATA: rd_mux = rx_data;
         REG_STATUS: rd_mux = {30'd0, done_q, busy};
         REG_CLKDIV: rd_mux = {24'd0, clkdiv_q};
         default:    rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         len_q    <= 6'd0;
         irq_en_q <= 1'b0;
         txdata_q <= 32'd0;
         clkdiv_q <= DIV_RESET;
         done_q   <= 1'b0;
      end else begin
         if (wr_ok) begin
            case (addr)
               REG_CTRL: begin
                  if (avs.byteenable[0]) len_q    <= avs.writedata[5:0];
                  if (avs.byteenable[1]) irq_en_q <= avs.writedata[CTRL_IRQ_EN];
               end
               REG_TXDATA: txdata_q <= be_merge(txdata_q, avs.writedata, avs.byteenable);
               REG_CLKDIV: if (avs.byteenable[0]) clkdiv_q <= avs.writedata[7:0];
               default: ;
            endcase
         end
         // Frame end wins; a start or W1C clear otherwise drops DONE.
         if (done_evt)
            done_q <= 1'b1;
         else if (start)
            done_q <= 1'b0;
         else if (wr_ok && (addr == REG_STATUS) && avs.writedata[STATUS_DONE])
            done_q <= 1'b0;
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         avs.readdata      <= 32'd0;
         avs.readdatavalid <= 1'b0;
      end else begin
         avs.readdatavalid <= avs.read;
         if (avs.read) avs.readdata <= rd_mux;
      end
   end

   assign irq = done_q && irq_en_q;

   sensor_spi_shifter #(
      .GAP_CYCLES (GAP_CYCLES)
   ) u_shifter (
      .clk      (clk_clk),
      .rst      (reset_reset),
      .start    (start),
      .len_in   (len_start),
      .tx_in    (txdata_q),
      .div_in   (clkdiv_q),
      .miso     (spi_miso),
      .sclk     (spi_sclk),
      .mosi     (spi_mosi),
      .cs_n     (spi_cs_n),
      .busy     (busy),
      .done_evt (done_evt),
      .rx_data  (rx_data)
   );

endmodule
